// File: rtl/dti_pkg.sv
// Shared types and helpers for the DTI stream join.
// Provides the default word type and the joined-width helper.
package dti_pkg;

  localparam int DTI_DIN_W = 16;

  typedef logic [DTI_DIN_W-1:0] dti_word_t;

  function automatic int join_w(
    input int size,
    input int din_w
  );
    return size * din_w;
  endfunction

endpackage

// File: rtl/dti_s_if.sv
// DTI stream interface: data, valid, ready.
// producer drives data/valid, consumer drives ready.
interface dti_s_if #(
  parameter int W = 16
) ();

  logic [W-1:0] data;
  logic         valid;
  logic         ready;

  modport producer (
    output data,
    output valid,
    input  ready
  );

  modport consumer (
    input  data,
    input  valid,
    output ready
  );

endinterface

// File: rtl/dti_join_slot.sv
// One-entry holding register for a single join input.
// Ports: clk, rst (async high), load, clear, d, q, full.
module dti_join_slot
  import dti_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         full
);

  logic         full_q;
  logic         full_d;
  logic [W-1:0] data_q;
  logic [W-1:0] data_d;

  // A load wins over clear: the old word leaves
  // and the new one is captured in the same cycle.
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (load) begin
      full_d = 1'b1;
      data_d = d;
    end else if (clear) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign q    = data_q;
  assign full = full_q;

endmodule

// File: rtl/dti_join.sv
// Joins SIZE DTI inputs into one SIZE*DIN_W transfer.
// Ports: clk, rst, din[SIZE] (consumer), dout (producer);
// join_cnt/stall_cnt exist only with DTI_JOIN_STATS_EN.
module dti_join
  import dti_pkg::*;
#(
  parameter int SIZE    = 2,
  parameter int DIN_W   = 16,
  parameter int STATS_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  dti_s_if.consumer          din [SIZE],
  dti_s_if.producer          dout
`ifdef DTI_JOIN_STATS_EN
  ,
  output logic [STATS_W-1:0] join_cnt,
  output logic [STATS_W-1:0] stall_cnt
`endif
);

  localparam int DOUT_W = join_w(SIZE, DIN_W);

  if (SIZE < 2 || STATS_W < 1) begin : g_bad_cfg
    $error("dti_join: SIZE must be >= 2, STATS_W >= 1");
  end

  logic [SIZE-1:0]   full;
  logic [SIZE-1:0]   load;
  logic [SIZE-1:0]   rdy;
  logic [DOUT_W-1:0] dout_data;
  logic              dout_valid;
  logic              hs_o;

  assign dout_valid = &full;
  assign hs_o       = dout_valid & dout.ready;
  assign dout.valid = dout_valid;
  assign dout.data  = dout_data;

  for (genvar i = 0; i < SIZE; i++) begin : g_ch
    // Ready may depend on dout.ready: a full
    // slot can refill in the cycle it drains.
    assign rdy[i]       = !full[i] | hs_o;
    assign din[i].ready = rdy[i];
    assign load[i]      = din[i].valid & rdy[i];

    dti_join_slot #(
      .W (DIN_W)
    ) u_slot (
      .clk   (clk),
      .rst   (rst),
      .load  (load[i]),
      .clear (hs_o),
      .d     (din[i].data),
      .q     (dout_data[i*DIN_W +: DIN_W]),
      .full  (full[i])
    );
  end

`ifdef DTI_JOIN_STATS_EN
  logic [STATS_W-1:0] join_cnt_q;
  logic [STATS_W-1:0] join_cnt_d;
  logic [STATS_W-1:0] stall_cnt_q;
  logic [STATS_W-1:0] stall_cnt_d;
  logic               stall;

  assign stall = dout_valid & !dout.ready;

  always_comb begin
    join_cnt_d  = join_cnt_q + STATS_W'(hs_o);
    stall_cnt_d = stall_cnt_q + STATS_W'(stall);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      join_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      join_cnt_q  <= join_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign join_cnt  = join_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_dti_join.sv
// Self-checking bench for dti_join (SIZE=2, DIN_W=16).
// Reference model: per-channel FIFOs of accepted words.
module tb_dti_join;
  import dti_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  v_r;
  dti_word_t   d_r [2];
  logic        rdy_r;
  logic [1:0]  rdy_w;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dti_s_if #(.W(16)) din_if [2] ();
  dti_s_if #(.W(32)) dout_if ();

  assign din_if[0].valid = v_r[0];
  assign din_if[0].data  = d_r[0];
  assign din_if[1].valid = v_r[1];
  assign din_if[1].data  = d_r[1];
  assign dout_if.ready   = rdy_r;
  assign rdy_w = {din_if[1].ready, din_if[0].ready};

`ifdef DTI_JOIN_STATS_EN
  logic [31:0] join_cnt;
  logic [31:0] stall_cnt;
  logic [1:0]  v3_r;
  logic [2:0]  join3;
  logic [2:0]  stall3;

  dti_s_if #(.W(16)) d3_if [2] ();
  dti_s_if #(.W(32)) o3_if ();

  assign d3_if[0].valid = v3_r[0];
  assign d3_if[0].data  = 16'h0003;
  assign d3_if[1].valid = v3_r[1];
  assign d3_if[1].data  = 16'h0030;
  assign o3_if.ready    = 1'b1;

  dti_join #(
    .SIZE    (2),
    .DIN_W   (16),
    .STATS_W (3)
  ) dut3 (
    .clk       (clk),
    .rst       (rst),
    .din       (d3_if),
    .dout      (o3_if),
    .join_cnt  (join3),
    .stall_cnt (stall3)
  );
`endif

  dti_join #(
    .SIZE    (2),
    .DIN_W   (16),
    .STATS_W (32)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .din  (din_if),
    .dout (dout_if)
`ifdef DTI_JOIN_STATS_EN
    ,
    .join_cnt  (join_cnt),
    .stall_cnt (stall_cnt)
`endif
  );

  // Reference model
  dti_word_t   q0[$];
  dti_word_t   q1[$];
  int          joins;
  int          stalls;
  logic        exp_valid;
  logic [1:0]  exp_ready;
  logic [31:0] exp_data;
  int          exp_joins;
  int          exp_stalls;

  task automatic model_reset();
    q0.delete();
    q1.delete();
    joins  = 0;
    stalls = 0;
  endtask

  task automatic drive(
    input logic      v0,
    input dti_word_t d0,
    input logic      v1,
    input dti_word_t d1,
    input logic      r
  );
    v_r[0] = v0;
    d_r[0] = d0;
    v_r[1] = v1;
    d_r[1] = d1;
    rdy_r  = r;
  endtask

  // Call before the edge; computes this cycle's
  // expectations, then books the handshakes.
  task automatic predict();
    logic hs;
    exp_valid = (q0.size() > 0) && (q1.size() > 0);
    exp_data  = '0;
    if (exp_valid) exp_data = {q1[0], q0[0]};
    hs = exp_valid && rdy_r;
    exp_ready[0] = (q0.size() == 0) || hs;
    exp_ready[1] = (q1.size() == 0) || hs;
    exp_joins  = joins;
    exp_stalls = stalls;
    if (hs) begin
      void'(q0.pop_front());
      void'(q1.pop_front());
      joins++;
    end else if (exp_valid) begin
      stalls++;
    end
    if (v_r[0] && exp_ready[0]) q0.push_back(d_r[0]);
    if (v_r[1] && exp_ready[1]) q1.push_back(d_r[1]);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(0, '0, 0, '0, 0);
`ifdef DTI_JOIN_STATS_EN
    v3_r = 2'b00;
`endif
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_chk++;
    if (dout_if.valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_valid got=%b exp=0", dout_if.valid);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    n_chk++;
    if (dout_if.valid !== 1'b0 || rdy_w !== 2'b11) begin
      n_fail++;
      $display("FAIL post_reset got v=%b r=%b exp v=0 r=11",
               dout_if.valid, rdy_w);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_latency();
    for (int c = 0; c < 8; c++) begin
      drive(c == 2, 16'h1111, c == 5, 16'h2222, 1'b1);
      @(negedge clk);
      predict();
      n_chk++;
      if (dout_if.valid !== (c == 6) || exp_valid !== (c == 6)) begin
        n_fail++;
        $display("FAIL lat_valid c=%0d got=%b exp=%b",
                 c, dout_if.valid, c == 6);
      end
      n_chk++;
      if (rdy_w !== exp_ready) begin
        n_fail++;
        $display("FAIL lat_ready c=%0d got=%b exp=%b",
                 c, rdy_w, exp_ready);
      end
      if (c == 6) begin
        n_chk++;
        if (dout_if.data !== 32'h2222_1111) begin
          n_fail++;
          $display("FAIL lat_data got=%h exp=22221111",
                   dout_if.data);
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_back_to_back();
    int seen;
    seen = 0;
    for (int c = 0; c <= 100; c++) begin
      drive(c < 100, dti_word_t'($urandom),
            c < 100, dti_word_t'($urandom), 1'b1);
      @(negedge clk);
      predict();
      if (dout_if.valid === 1'b1) seen++;
      n_chk++;
      if (dout_if.valid !== (c >= 1)) begin
        n_fail++;
        $display("FAIL b2b_gap c=%0d got=%b exp=%b",
                 c, dout_if.valid, c >= 1);
      end
      if (exp_valid) begin
        n_chk++;
        if (dout_if.data !== exp_data) begin
          n_fail++;
          $display("FAIL b2b_data c=%0d got=%h exp=%h",
                   c, dout_if.data, exp_data);
        end
      end
      @(posedge clk);
      #1;
    end
    n_chk++;
    if (seen != 100) begin
      n_fail++;
      $display("FAIL b2b_count got=%0d exp=100", seen);
    end
    drive(0, '0, 0, '0, 1'b1);
    @(negedge clk);
    predict();
    @(posedge clk);
    #1;
  endtask

  task automatic test_backpressure();
    drive(1, 16'h0101, 1, 16'h0202, 1'b0);
    @(negedge clk);
    predict();
    @(posedge clk);
    #1;
    for (int c = 0; c < 4; c++) begin
      drive(1, 16'hAAAA, 0, '0, 1'b0);
      @(negedge clk);
      predict();
      n_chk++;
      if (rdy_w[0] !== 1'b0 || exp_ready[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_ready c=%0d got=%b exp=0", c, rdy_w[0]);
      end
      n_chk++;
      if (dout_if.valid !== 1'b1 ||
          dout_if.data !== 32'h0202_0101) begin
        n_fail++;
        $display("FAIL bp_hold c=%0d got v=%b d=%h exp v=1 d=02020101",
                 c, dout_if.valid, dout_if.data);
      end
      @(posedge clk);
      #1;
    end
    drive(1, 16'hAAAA, 0, '0, 1'b1);
    @(negedge clk);
    predict();
    n_chk++;
    if (rdy_w !== 2'b11) begin
      n_fail++;
      $display("FAIL bp_accept got=%b exp=11", rdy_w);
    end
    @(posedge clk);
    #1;
    drive(0, '0, 1, 16'hBBBB, 1'b1);
    @(negedge clk);
    predict();
    n_chk++;
    if (dout_if.valid !== 1'b0 || rdy_w !== 2'b10) begin
      n_fail++;
      $display("FAIL bp_half got v=%b r=%b exp v=0 r=10",
               dout_if.valid, rdy_w);
    end
    @(posedge clk);
    #1;
    drive(0, '0, 0, '0, 1'b1);
    @(negedge clk);
    predict();
    n_chk++;
    if (dout_if.valid !== 1'b1 ||
        dout_if.data !== 32'hBBBB_AAAA) begin
      n_fail++;
      $display("FAIL bp_next got v=%b d=%h exp v=1 d=bbbbaaaa",
               dout_if.valid, dout_if.data);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_simultaneous();
    drive(1, 16'h0001, 1, 16'h0002, 1'b0);
    @(negedge clk);
    predict();
    @(posedge clk);
    #1;
    drive(1, 16'h0003, 1, 16'h0004, 1'b1);
    @(negedge clk);
    predict();
    n_chk++;
    if (rdy_w !== 2'b11 || dout_if.data !== 32'h0002_0001) begin
      n_fail++;
      $display("FAIL sim_swap got r=%b d=%h exp r=11 d=00020001",
               rdy_w, dout_if.data);
    end
    @(posedge clk);
    #1;
    drive(0, '0, 0, '0, 1'b1);
    @(negedge clk);
    predict();
    n_chk++;
    if (dout_if.valid !== 1'b1 ||
        dout_if.data !== 32'h0004_0003) begin
      n_fail++;
      $display("FAIL sim_new got v=%b d=%h exp v=1 d=00040003",
               dout_if.valid, dout_if.data);
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    predict();
    n_chk++;
    if (dout_if.valid !== 1'b0) begin
      n_fail++;
      $display("FAIL sim_dup got v=%b exp v=0", dout_if.valid);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      drive($urandom_range(0, 1) == 1, dti_word_t'($urandom),
            $urandom_range(0, 2) != 0, dti_word_t'($urandom),
            $urandom_range(0, 3) != 0);
      @(negedge clk);
      predict();
      n_chk++;
      if (dout_if.valid !== exp_valid || rdy_w !== exp_ready) begin
        n_fail++;
        $display("FAIL rnd_hs c=%0d got v=%b r=%b exp v=%b r=%b",
                 c, dout_if.valid, rdy_w, exp_valid, exp_ready);
      end
      if (exp_valid) begin
        n_chk++;
        if (dout_if.data !== exp_data) begin
          n_fail++;
          $display("FAIL rnd_data c=%0d got=%h exp=%h",
                   c, dout_if.data, exp_data);
        end
      end
      @(posedge clk);
      #1;
    end
    drive(0, '0, 0, '0, 1'b1);
    repeat (2) begin
      @(negedge clk);
      predict();
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_async_reset();
    drive(1, 16'h3333, 1, 16'h4444, 1'b0);
    @(negedge clk);
    predict();
    @(posedge clk);
    #1;
    drive(0, '0, 0, '0, 1'b0);
    @(negedge clk);
    predict();
    n_chk++;
    if (dout_if.valid !== 1'b1) begin
      n_fail++;
      $display("FAIL ar_pre got v=%b exp v=1", dout_if.valid);
    end
    #2;
    rst = 1'b1;
    #1;
    n_chk++;
    if (dout_if.valid !== 1'b0 || rdy_w !== 2'b11) begin
      n_fail++;
      $display("FAIL ar_drop got v=%b r=%b exp v=0 r=11",
               dout_if.valid, rdy_w);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    drive(1, 16'h5555, 0, '0, 1'b1);
    @(negedge clk);
    predict();
    @(posedge clk);
    #1;
    drive(0, '0, 1, 16'h9999, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    n_chk++;
    if (dout_if.valid !== 1'b0 || rdy_w[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL ar_mid got v=%b r0=%b exp v=0 r0=1",
               dout_if.valid, rdy_w[0]);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    drive(1, 16'h7777, 0, '0, 1'b1);
    @(negedge clk);
    predict();
    @(posedge clk);
    #1;
    drive(0, '0, 1, 16'h8888, 1'b1);
    @(negedge clk);
    predict();
    n_chk++;
    if (dout_if.valid !== 1'b0) begin
      n_fail++;
      $display("FAIL ar_stale got v=%b d=%h exp v=0",
               dout_if.valid, dout_if.data);
    end
    @(posedge clk);
    #1;
    drive(0, '0, 0, '0, 1'b1);
    @(negedge clk);
    predict();
    n_chk++;
    if (dout_if.valid !== 1'b1 ||
        dout_if.data !== 32'h8888_7777) begin
      n_fail++;
      $display("FAIL ar_fresh got v=%b d=%h exp v=1 d=88887777",
               dout_if.valid, dout_if.data);
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    predict();
    n_chk++;
    if (dout_if.valid !== 1'b0) begin
      n_fail++;
      $display("FAIL ar_after got v=%b exp v=0", dout_if.valid);
    end
    @(posedge clk);
    #1;
  endtask

`ifdef DTI_JOIN_STATS_EN
  task automatic test_stats();
    rst = 1'b1;
    drive(0, '0, 0, '0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    for (int c = 0; c < 20; c++) begin
      if (c == 0) drive(1, 16'h00C0, 1, 16'h00C1, 1'b0);
      else if (c < 8) drive(0, '0, 0, '0, 1'b0);
      else if (c < 17) drive(1, dti_word_t'(c), 1,
                             dti_word_t'(c + 100), 1'b1);
      else drive(0, '0, 0, '0, 1'b1);
      @(negedge clk);
      predict();
      n_chk++;
      if (join_cnt !== 32'(exp_joins) ||
          stall_cnt !== 32'(exp_stalls)) begin
        n_fail++;
        $display("FAIL st_cnt c=%0d got j=%0d s=%0d exp j=%0d s=%0d",
                 c, join_cnt, stall_cnt, exp_joins, exp_stalls);
      end
      @(posedge clk);
      #1;
    end
    n_chk++;
    if (join_cnt !== 32'd10 || stall_cnt !== 32'd7) begin
      n_fail++;
      $display("FAIL st_total got j=%0d s=%0d exp j=10 s=7",
               join_cnt, stall_cnt);
    end
    for (int c = 0; c < 10; c++) begin
      v3_r = (c < 9) ? 2'b11 : 2'b00;
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    n_chk++;
    if (join3 !== 3'd1 || stall3 !== 3'd0) begin
      n_fail++;
      $display("FAIL st_wrap got j=%0d s=%0d exp j=1 s=0",
               join3, stall3);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_latency();
    test_back_to_back();
    test_backpressure();
    test_simultaneous();
    test_random();
    test_async_reset();
`ifdef DTI_JOIN_STATS_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
